// File: rtl/fht_engine_top.sv
// In-place radix-2 Fast Hartley Transform engine with ping-pong RAMs A/B.
// The host loads bit-reversed samples into RAM A, pulses iSTART and reads
// the H/N scaled spectrum back from RAM A once oRDY returns high.
module fht_engine_top #(
  parameter int D_BIT  = 16,
  parameter int A_BIT  = 6,
  parameter int STAGES = A_BIT + 2
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iSTART,
  input  logic signed [D_BIT-2:0] iDATA,
  input  logic [A_BIT-1:0]        iADDR_WR,
  input  logic                    iWE_0,
  input  logic                    iWE_1,
  input  logic                    iWE_2,
  input  logic                    iWE_3,
  input  logic [A_BIT-1:0]        iADDR_RD_0,
  input  logic [A_BIT-1:0]        iADDR_RD_1,
  input  logic [A_BIT-1:0]        iADDR_RD_2,
  input  logic [A_BIT-1:0]        iADDR_RD_3,
  output logic signed [D_BIT-1:0] oDATA_0,
  output logic signed [D_BIT-1:0] oDATA_1,
  output logic signed [D_BIT-1:0] oDATA_2,
  output logic signed [D_BIT-1:0] oDATA_3,
  output logic                    oRDY
);

  localparam int N     = 4 << A_BIT;
  localparam int P_BIT = A_BIT + 2;
  localparam int HALF  = N / 2;
  localparam int S_BIT = $clog2(STAGES + 1);
  localparam int W_ACC = 2 * D_BIT + 1;
  localparam logic signed [W_ACC-1:0] RND = W_ACC'(1) <<< (D_BIT - 3);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [S_BIT-1:0]   cnt_stage_q, cnt_stage_d;
  logic [P_BIT-2:0]   bfly_q, bfly_d;

  // Point k lives at bank k%4, address k/4, i.e. flat index {addr, bank}.
  logic signed [D_BIT-1:0] ram_a_q [N];
  logic signed [D_BIT-1:0] ram_b_q [N];

  // Quarter-to-half-wave twiddle ROM in Q1.(D_BIT-2), round half-up.
  logic signed [D_BIT-1:0] cos_rom [HALF];
  logic signed [D_BIT-1:0] sin_rom [HALF];
  for (genvar t = 0; t < HALF; t++) begin : g_tw
    localparam real ANG   = 2.0 * 3.14159265358979323846 * t / N;
    localparam int  COS_V = $rtoi($floor((2.0 ** (D_BIT - 2)) * $cos(ANG) + 0.5));
    localparam int  SIN_V = $rtoi($floor((2.0 ** (D_BIT - 2)) * $sin(ANG) + 0.5));
    assign cos_rom[t] = D_BIT'(COS_V);
    assign sin_rom[t] = D_BIT'(SIN_V);
  end

  logic [S_BIT-1:0]        sh, tw_sh;
  logic [P_BIT-1:0]        m_w, k_w, base_w, ia, ib, ic;
  logic [P_BIT-2:0]        tw_idx;
  logic                    src_a;
  logic signed [D_BIT-1:0] a_w, b_w, c_w, out_p, out_m;
  logic signed [W_ACC-1:0] pb, pc, acc;
  logic signed [D_BIT:0]   t_w, sum_p, sum_m;
  logic signed [D_BIT-1:0] wdata;

  assign wdata = D_BIT'(iDATA);
  assign oRDY  = (state_q == IDLE);

  // Butterfly address decode, twiddle lookup and arithmetic for bfly_q.
  always_comb begin
    sh     = cnt_stage_q - S_BIT'(1);
    tw_sh  = S_BIT'(STAGES) - cnt_stage_q;
    m_w    = P_BIT'(1) << sh;
    k_w    = P_BIT'(bfly_q) & (m_w - P_BIT'(1));
    base_w = (P_BIT'(bfly_q) >> sh) << cnt_stage_q;
    ia     = base_w + k_w;
    ib     = ia + m_w;
    ic     = base_w + m_w + ((m_w - k_w) & (m_w - P_BIT'(1)));
    tw_idx = (P_BIT-1)'(k_w << tw_sh);
    src_a  = cnt_stage_q[0];
    a_w    = src_a ? ram_a_q[ia] : ram_b_q[ia];
    b_w    = src_a ? ram_a_q[ib] : ram_b_q[ib];
    c_w    = src_a ? ram_a_q[ic] : ram_b_q[ic];
    pb     = W_ACC'(b_w) * W_ACC'(cos_rom[tw_idx]);
    pc     = W_ACC'(c_w) * W_ACC'(sin_rom[tw_idx]);
    acc    = pb + pc + RND;
    if (k_w == '0) t_w = (D_BIT+1)'(b_w);
    else           t_w = (D_BIT+1)'(acc >>> (D_BIT - 2));
    sum_p  = (D_BIT+1)'(a_w) + t_w;
    sum_m  = (D_BIT+1)'(a_w) - t_w;
    out_p  = D_BIT'(sum_p >>> 1);
    out_m  = D_BIT'(sum_m >>> 1);
  end

  // Controller: one butterfly per cycle; the stage advances on its last write.
  always_comb begin
    state_d     = state_q;
    cnt_stage_d = cnt_stage_q;
    bfly_d      = bfly_q;
    unique case (state_q)
      IDLE: if (iSTART) begin
        state_d     = RUN;
        cnt_stage_d = S_BIT'(1);
        bfly_d      = '0;
      end
      RUN: begin
        bfly_d = bfly_q + (P_BIT-1)'(1);
        if (bfly_q == '1) begin
          if (cnt_stage_q == S_BIT'(STAGES)) begin
            state_d     = DONE;
            cnt_stage_d = '0;
          end else begin
            cnt_stage_d = cnt_stage_q + S_BIT'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q     <= IDLE;
      cnt_stage_q <= '0;
      bfly_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_stage_q <= cnt_stage_d;
      bfly_q      <= bfly_d;
    end
  end

  // RAM A: host load while idle, engine results on even stages.
  always_ff @(posedge iCLK) begin
    if (state_q == IDLE) begin
      if (iWE_0) ram_a_q[{iADDR_WR, 2'd0}] <= wdata;
      if (iWE_1) ram_a_q[{iADDR_WR, 2'd1}] <= wdata;
      if (iWE_2) ram_a_q[{iADDR_WR, 2'd2}] <= wdata;
      if (iWE_3) ram_a_q[{iADDR_WR, 2'd3}] <= wdata;
    end else if (state_q == RUN && !src_a) begin
      ram_a_q[ia] <= out_p;
      ram_a_q[ib] <= out_m;
    end
  end

  // RAM B: engine results on odd stages.
  always_ff @(posedge iCLK) begin
    if (state_q == RUN && src_a) begin
      ram_b_q[ia] <= out_p;
      ram_b_q[ib] <= out_m;
    end
  end

  // Registered host read ports on RAM A.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      oDATA_0 <= '0;
      oDATA_1 <= '0;
      oDATA_2 <= '0;
      oDATA_3 <= '0;
    end else begin
      oDATA_0 <= ram_a_q[{iADDR_RD_0, 2'd0}];
      oDATA_1 <= ram_a_q[{iADDR_RD_1, 2'd1}];
      oDATA_2 <= ram_a_q[{iADDR_RD_2, 2'd2}];
      oDATA_3 <= ram_a_q[{iADDR_RD_3, 2'd3}];
    end
  end

endmodule

// File: tb/tb_fht_engine_top.sv
// Scoreboard bench for fht_engine_top: stimulus pushes expected read data
// and per-stage RAM snapshots; monitors pop and compare as the DUT presents them.
module tb_fht_engine_top;

  localparam int D_BIT  = 16;
  localparam int A_BIT  = 6;
  localparam int N      = 4 << A_BIT;
  localparam int STAGES = A_BIT + 2;
  localparam int RUN_BOUND = STAGES * (N + 16);

  logic                    iCLK, iRESET, iSTART;
  logic signed [D_BIT-2:0] iDATA;
  logic [A_BIT-1:0]        iADDR_WR;
  logic                    iWE_0, iWE_1, iWE_2, iWE_3;
  logic [A_BIT-1:0]        iADDR_RD_0, iADDR_RD_1, iADDR_RD_2, iADDR_RD_3;
  logic signed [D_BIT-1:0] oDATA_0, oDATA_1, oDATA_2, oDATA_3;
  logic                    oRDY;

  fht_engine_top #(.D_BIT(D_BIT), .A_BIT(A_BIT)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iDATA(iDATA),
    .iADDR_WR(iADDR_WR),
    .iWE_0(iWE_0), .iWE_1(iWE_1), .iWE_2(iWE_2), .iWE_3(iWE_3),
    .iADDR_RD_0(iADDR_RD_0), .iADDR_RD_1(iADDR_RD_1),
    .iADDR_RD_2(iADDR_RD_2), .iADDR_RD_3(iADDR_RD_3),
    .oDATA_0(oDATA_0), .oDATA_1(oDATA_1), .oDATA_2(oDATA_2), .oDATA_3(oDATA_3),
    .oRDY(oRDY)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  int checks = 0;
  int errors = 0;

  int mdl_in [N];
  int mdl    [N];
  int tmp    [N];
  int exp_arr[N];

  int exp_q[$];
  int pt_q[$];
  int stg_num_q[$];
  int snap_q[$];

  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;
  bit   stage_chk_en = 1'b1;
  int   prev_stage = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int tw_val(input int t, input bit is_sin);
    real ang, v;
    ang = 2.0 * 3.141592653589793 * t / N;
    v   = is_sin ? $sin(ang) : $cos(ang);
    return $rtoi($floor(16384.0 * v + 0.5));
  endfunction

  function automatic int wrap17(input int v);
    int r;
    r = v & 32'h1FFFF;
    if (r >= 65536) r = r - 131072;
    return r;
  endfunction

  function automatic void mdl_stage(input int s);
    int l, m, a, b, c, t, p, tw;
    l = 1 << s;
    m = l / 2;
    for (int i = 0; i < N; i += l) begin
      for (int k = 0; k < m; k++) begin
        a = mdl[i + k];
        b = mdl[i + m + k];
        c = mdl[i + m + ((m - k) % m)];
        if (k == 0) t = b;
        else begin
          tw = k * (N / l);
          p  = b * tw_val(tw, 1'b0) + c * tw_val(tw, 1'b1);
          t  = wrap17((p + 8192) >>> 14);
        end
        tmp[i + k]     = wrap17(a + t) >>> 1;
        tmp[i + m + k] = wrap17(a - t) >>> 1;
      end
    end
    for (int q = 0; q < N; q++) mdl[q] = tmp[q];
  endfunction

  task automatic push_model_stages();
    for (int q = 0; q < N; q++) mdl[q] = mdl_in[q];
    for (int s = 1; s <= STAGES; s++) begin
      mdl_stage(s);
      stg_num_q.push_back(s);
      for (int q = 0; q < N; q++) snap_q.push_back(mdl[q]);
    end
  endtask

  // ---------------- monitors ----------------
  always @(posedge iCLK) rd_vld <= rd_req;

  // Read-data monitor: four banks presented per valid cycle.
  always @(negedge iCLK) begin
    if (rd_vld) begin
      if (exp_q.size() < 4) chk("rd_underflow", exp_q.size(), 4);
      else begin
        chk($sformatf("rd_pt%0d", pt_q.pop_front()), int'(oDATA_0), exp_q.pop_front());
        chk($sformatf("rd_pt%0d", pt_q.pop_front()), int'(oDATA_1), exp_q.pop_front());
        chk($sformatf("rd_pt%0d", pt_q.pop_front()), int'(oDATA_2), exp_q.pop_front());
        chk($sformatf("rd_pt%0d", pt_q.pop_front()), int'(oDATA_3), exp_q.pop_front());
      end
    end
  end

  // Stage monitor: on each cnt_stage change compare the finished stage's
  // destination RAM (B for odd stages, A for even) with the model snapshot.
  always @(negedge iCLK) begin
    int cur, num, bad, first, got, want;
    cur = int'(dut.cnt_stage_q);
    if (stage_chk_en && cur != prev_stage) begin
      if (cur != 0) chk("stage_step", cur, prev_stage + 1);
      if (prev_stage != 0) begin
        if (stg_num_q.size() == 0 || snap_q.size() < N) chk("stage_underflow", stg_num_q.size(), 1);
        else begin
          num = stg_num_q.pop_front();
          chk("stage_id", prev_stage, num);
          bad = 0;
          first = -1;
          for (int q = 0; q < N; q++) begin
            want = snap_q.pop_front();
            got  = (prev_stage % 2 == 1) ? int'(dut.ram_b_q[q]) : int'(dut.ram_a_q[q]);
            if (got != want) begin
              bad++;
              if (first < 0) first = q;
            end
          end
          chk($sformatf("stage%0d_ram_bad_points(first=%0d)", prev_stage, first), bad, 0);
        end
      end
    end
    prev_stage = cur;
  end

  // ---------------- stimulus tasks ----------------
  task automatic write_point(input int k, input int v);
    iADDR_WR = A_BIT'(k >> 2);
    iDATA    = (D_BIT-1)'(v);
    iWE_0 = (k % 4 == 0);
    iWE_1 = (k % 4 == 1);
    iWE_2 = (k % 4 == 2);
    iWE_3 = (k % 4 == 3);
  endtask

  task automatic clear_we();
    iWE_0 = 1'b0; iWE_1 = 1'b0; iWE_2 = 1'b0; iWE_3 = 1'b0;
  endtask

  // Loads mdl_in; optionally raises iSTART together with the final write.
  task automatic load_and_start(input bit start_with_last);
    for (int k = 0; k < N; k++) begin
      write_point(k, mdl_in[k]);
      if (k == N - 1 && start_with_last) iSTART = 1'b1;
      tick();
    end
    clear_we();
    if (!start_with_last) begin
      iSTART = 1'b1;
      tick();
    end
    iSTART = 1'b0;
    chk("rdy_low_after_start", int'(oRDY), 0);
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (!oRDY && cyc < RUN_BOUND + 8) begin
      tick();
      cyc++;
    end
    chk("run_done_in_bound", int'(oRDY && cyc <= RUN_BOUND), 1);
  endtask

  task automatic read_all();
    for (int a = 0; a < N / 4; a++) begin
      iADDR_RD_0 = A_BIT'(a); iADDR_RD_1 = A_BIT'(a);
      iADDR_RD_2 = A_BIT'(a); iADDR_RD_3 = A_BIT'(a);
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(exp_arr[a * 4 + b]);
        pt_q.push_back(a * 4 + b);
      end
      rd_req = 1'b1;
      tick();
    end
    rd_req = 1'b0;
    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic random_run(input bit start_with_last);
    for (int k = 0; k < N; k++) mdl_in[k] = int'($urandom_range(0, 32767)) - 16384;
    push_model_stages();
    load_and_start(start_with_last);
    wait_done();
    for (int k = 0; k < N; k++) exp_arr[k] = mdl[k];
    read_all();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    iRESET = 1'b1; iSTART = 1'b0; iDATA = '0; iADDR_WR = '0;
    clear_we();
    iADDR_RD_0 = '0; iADDR_RD_1 = '0; iADDR_RD_2 = '0; iADDR_RD_3 = '0;
    repeat (3) @(posedge iCLK);
    #1;
    iRESET = 1'b0;

    // Reset state
    chk("reset_rdy", int'(oRDY), 1);
    chk("reset_cnt_stage", int'(dut.cnt_stage_q), 0);
    chk("reset_odata0", int'(oDATA_0), 0);
    chk("reset_odata1", int'(oDATA_1), 0);
    chk("reset_odata2", int'(oDATA_2), 0);
    chk("reset_odata3", int'(oDATA_3), 0);

    // Impulse: 12800 at point 0 -> every point 12800/256 = 50
    for (int k = 0; k < N; k++) mdl_in[k] = 0;
    mdl_in[0] = 12800;
    push_model_stages();
    load_and_start(1'b0);
    wait_done();
    for (int k = 0; k < N; k++) exp_arr[k] = 50;
    read_all();
    repeat (4) tick();
    chk("rdy_stays_high", int'(oRDY), 1);

    // Idle write of -7 to bank 2 addr 5, read back one cycle later
    iADDR_WR = 6'd5; iDATA = -15'sd7; iWE_2 = 1'b1;
    tick();
    clear_we();
    iADDR_RD_0 = 6'd5; iADDR_RD_1 = 6'd5; iADDR_RD_2 = 6'd5; iADDR_RD_3 = 6'd5;
    exp_q.push_back(50); exp_q.push_back(50); exp_q.push_back(-7); exp_q.push_back(50);
    pt_q.push_back(20); pt_q.push_back(21); pt_q.push_back(22); pt_q.push_back(23);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    chk("rw_drained", exp_q.size(), 0);

    // DC: all 100 -> point 0 = 100, others 0
    for (int k = 0; k < N; k++) mdl_in[k] = 100;
    push_model_stages();
    load_and_start(1'b0);
    wait_done();
    for (int k = 0; k < N; k++) exp_arr[k] = (k == 0) ? 100 : 0;
    read_all();

    // Busy protection: writes and a second start mid-run are ignored
    push_model_stages();
    load_and_start(1'b0);
    repeat (300) tick();
    iADDR_WR = 6'd0; iDATA = 15'sd1234;
    iWE_0 = 1'b1; iWE_1 = 1'b1; iWE_2 = 1'b1; iWE_3 = 1'b1;
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
    repeat (2) tick();
    iADDR_WR = 6'd9;
    tick();
    clear_we();
    chk("busy_rdy_low", int'(oRDY), 0);
    wait_done();
    read_all();

    // Reset during stage 3 aborts the run
    stage_chk_en = 1'b0;
    load_and_start(1'b0);
    cyc = 0;
    while (int'(dut.cnt_stage_q) != 3 && cyc < RUN_BOUND) begin
      tick();
      cyc++;
    end
    chk("reached_stage3", int'(dut.cnt_stage_q), 3);
    iRESET = 1'b1;
    tick();
    iRESET = 1'b0;
    chk("abort_rdy", int'(oRDY), 1);
    chk("abort_cnt_stage", int'(dut.cnt_stage_q), 0);
    chk("abort_odata0", int'(oDATA_0), 0);
    tick();
    stage_chk_en = 1'b1;

    // Fresh run after the abort, then random vectors (first one starts
    // in the same cycle as its last load write)
    random_run(1'b0);
    for (int r = 0; r < 20; r++) random_run(r == 0);

    chk("stage_queue_empty", stg_num_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
